// File: rtl/load_store_unit.sv
// load_store_unit: core-side initiator for the word-wide data memory.
// Runs one load/store at a time. Sub-word stores are done as read-modify-write
// because the memory has no byte enables. Loads are sign/zero extended.
// Optional feature macro: LSU_MISALIGN_TRAP_EN. When it is defined, misaligned
// H/HU/W accesses fault. When it is undefined, the offending low address bits
// are ignored.
module load_store_unit #(
    parameter int MEM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        mem_rw,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    localparam logic [29:0] WORDS = 30'(MEM_WORDS);

    state_t      state, state_next;
    logic        accept;
    logic        req_fault;
    logic        op_we;
    logic [2:0]  op_funct3;
    logic [1:0]  op_lane;
    logic [31:0] op_wdata;
    logic        op_fault;
    logic [31:0] word;
    logic [31:0] addr_reg;
    logic [29:0] word_index;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic [31:0] merged;

    assign accept     = req_valid && (state == IDLE);
    assign word_index = req_addr[31:2] % WORDS;

    // Classify an incoming request as faulting (bad funct3 or optional misalignment)
    always_comb begin
        req_fault = 1'b0;
        case (req_funct3)
            3'b011, 3'b110, 3'b111: req_fault = 1'b1;
            3'b100, 3'b101:         req_fault = req_we;
            default:                req_fault = 1'b0;
        endcase
`ifdef LSU_MISALIGN_TRAP_EN
        if ((req_funct3 == 3'b001 || req_funct3 == 3'b101) && req_addr[0])
            req_fault = 1'b1;
        if (req_funct3 == 3'b010 && req_addr[1:0] != 2'b00)
            req_fault = 1'b1;
`endif
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Latch the request on accept and capture the memory word during READ
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_we     <= 1'b0;
            op_funct3 <= 3'b000;
            op_lane   <= 2'b00;
            op_wdata  <= 32'h0;
            op_fault  <= 1'b0;
            addr_reg  <= 32'h0;
            word      <= 32'h0;
        end else begin
            if (accept) begin
                op_we     <= req_we;
                op_funct3 <= req_funct3;
                op_lane   <= req_addr[1:0];
                op_wdata  <= req_wdata;
                op_fault  <= req_fault;
                addr_reg  <= {2'b00, word_index};
            end
            if (state == READ)
                word <= mem_rdata;
        end
    end

    // Next-state sequencing: faults skip memory, sub-word stores go through READ
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_fault)
                        state_next = RESP;
                    else if (!req_we)
                        state_next = READ;
                    else if (req_funct3 == 3'b010)
                        state_next = WRITE;
                    else
                        state_next = READ;
                end
            end
            READ:    state_next = op_we ? WRITE : RESP;
            WRITE:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Extract and extend the addressed byte/half of the captured word
    always_comb begin
        byte_sel  = 8'h0;
        half_sel  = op_lane[1] ? word[31:16] : word[15:0];
        load_data = word;
        case (op_lane)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        case (op_funct3[1:0])
            2'b00:   load_data = op_funct3[2] ? {24'h0, byte_sel}
                                              : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   load_data = op_funct3[2] ? {16'h0, half_sel}
                                              : {{16{half_sel[15]}}, half_sel};
            default: load_data = word;
        endcase
    end

    // Build the write word: full store data, or the captured word with one lane replaced
    always_comb begin
        merged = word;
        case (op_funct3[1:0])
            2'b00: begin
                case (op_lane)
                    2'd0:    merged[7:0]   = op_wdata[7:0];
                    2'd1:    merged[15:8]  = op_wdata[7:0];
                    2'd2:    merged[23:16] = op_wdata[7:0];
                    default: merged[31:24] = op_wdata[7:0];
                endcase
            end
            2'b01: begin
                if (op_lane[1])
                    merged[31:16] = op_wdata[15:0];
                else
                    merged[15:0]  = op_wdata[15:0];
            end
            default: merged = op_wdata;
        endcase
    end

    // Outputs decoded from the state register so reset silences them immediately
    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
        resp_fault = (state == RESP) && op_fault;
        resp_rdata = ((state == RESP) && !op_fault && !op_we) ? load_data : 32'h0;
        mem_rw     = (state == WRITE);
        mem_wdata  = (state == WRITE) ? merged : 32'h0;
        mem_addr   = addr_reg;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed bench for load_store_unit with a behavioural
// word memory and a scoreboard of expected responses.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic        mem_rw;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:4095];

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          lat;
        int          wr;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    load_store_unit #(.MEM_WORDS(4096)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_fault (resp_fault),
        .mem_rw     (mem_rw),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory: combinational read, write on the clock edge
    assign mem_rdata = mem[mem_addr[11:0]];
    always @(posedge clk) begin
        if (mem_rw)
            mem[mem_addr[11:0]] <= mem_wdata;
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, then wait (bounded) for its response and score it
    task automatic apply_stimulus(input logic we, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [31:0] exp_rdata, input logic exp_fault,
                                  input int exp_lat, input int exp_wr, input string tag);
        exp_t e;
        int   lat;
        int   wr;
        bit   done;
        check_output({tag, ".ready"}, {31'h0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        e.rdata = exp_rdata;
        e.fault = exp_fault;
        e.lat   = exp_lat;
        e.wr    = exp_wr;
        sb.push_back(e);
        tick();
        req_valid = 1'b0;
        lat  = 1;
        wr   = 0;
        done = 1'b0;
        while (!done && lat <= 8) begin
            if (mem_rw && wr == 0)
                wr = lat;
            if (resp_valid)
                done = 1'b1;
            else begin
                tick();
                lat++;
            end
        end
        e = sb.pop_front();
        if (!done) begin
            checks++;
            errors++;
            $error("[TB] FAIL %s.timeout observed=no response expected=response", tag);
        end else begin
            check_output({tag, ".rdata"}, resp_rdata, e.rdata);
            check_output({tag, ".fault"}, {31'h0, resp_fault}, {31'h0, e.fault});
            check_output({tag, ".latency"}, lat, e.lat);
            check_output({tag, ".write_cycle"}, wr, e.wr);
        end
        tick();
    endtask

    initial begin
        exp_t e;
        bit   seen_resp;
        bit   seen_rw;

        for (int i = 0; i < 4096; i++)
            mem[i] = 32'h0;
        mem[1]  = 32'h80FF_7F80;
        mem[2]  = 32'h1122_3344;
        mem[3]  = 32'hDEAD_BEEF;
        mem[5]  = 32'h8765_4321;

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        repeat (2) tick();

        check_output("reset.req_ready",  {31'h0, req_ready},  32'd1);
        check_output("reset.resp_valid", {31'h0, resp_valid}, 32'd0);
        check_output("reset.resp_fault", {31'h0, resp_fault}, 32'd0);
        check_output("reset.mem_rw",     {31'h0, mem_rw},     32'd0);
        check_output("reset.mem_addr",   mem_addr,            32'h0);
        check_output("reset.mem_wdata",  mem_wdata,           32'h0);
        check_output("reset.resp_rdata", resp_rdata,          32'h0);

        rst_n = 1'b1;
        tick();

        apply_stimulus(1'b0, 3'b010, 32'h14, 32'h0, 32'h8765_4321, 1'b0, 2, 0, "lw_0x14");

        apply_stimulus(1'b0, 3'b000, 32'h4, 32'h0, 32'hFFFF_FF80, 1'b0, 2, 0, "lb_0x4");
        apply_stimulus(1'b0, 3'b100, 32'h4, 32'h0, 32'h0000_0080, 1'b0, 2, 0, "lbu_0x4");
        apply_stimulus(1'b0, 3'b000, 32'h5, 32'h0, 32'h0000_007F, 1'b0, 2, 0, "lb_0x5");
        apply_stimulus(1'b0, 3'b001, 32'h6, 32'h0, 32'hFFFF_80FF, 1'b0, 2, 0, "lh_0x6");
        apply_stimulus(1'b0, 3'b101, 32'h6, 32'h0, 32'h0000_80FF, 1'b0, 2, 0, "lhu_0x6");

        apply_stimulus(1'b1, 3'b000, 32'h9, 32'h0000_00AA, 32'h0, 1'b0, 3, 2, "sb_0x9");
        check_output("sb_0x9.mem", mem[2], 32'h1122_AA44);
        apply_stimulus(1'b1, 3'b001, 32'hA, 32'h0000_BEEF, 32'h0, 1'b0, 3, 2, "sh_0xA");
        check_output("sh_0xA.mem", mem[2], 32'hBEEF_AA44);

`ifdef LSU_MISALIGN_TRAP_EN
        apply_stimulus(1'b1, 3'b010, 32'h2, 32'h5555_5555, 32'h0, 1'b1, 1, 0, "sw_0x2");
        check_output("sw_0x2.mem", mem[0], 32'h0);
        apply_stimulus(1'b0, 3'b001, 32'h5, 32'h0, 32'h0, 1'b1, 1, 0, "lh_0x5");
`else
        apply_stimulus(1'b1, 3'b010, 32'h2, 32'h5555_5555, 32'h0, 1'b0, 2, 1, "sw_0x2");
        check_output("sw_0x2.mem", mem[0], 32'h5555_5555);
        apply_stimulus(1'b0, 3'b001, 32'h5, 32'h0, 32'h0000_7F80, 1'b0, 2, 0, "lh_0x5");
`endif

        apply_stimulus(1'b1, 3'b100, 32'h8, 32'h0000_0011, 32'h0, 1'b1, 1, 0, "store_f3_100");
        check_output("store_f3_100.mem", mem[2], 32'hBEEF_AA44);
        apply_stimulus(1'b0, 3'b011, 32'h14, 32'h0, 32'h0, 1'b1, 1, 0, "load_f3_011");
        apply_stimulus(1'b0, 3'b110, 32'h14, 32'h0, 32'h0, 1'b1, 1, 0, "load_f3_110");

        apply_stimulus(1'b0, 3'b010, 32'h4014, 32'h0, 32'h8765_4321, 1'b0, 2, 0, "lw_wrap");

        // Reset in the READ cycle of a byte store: the store must vanish
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'hC;
        req_wdata  = 32'h0000_0011;
        tick();
        req_valid = 1'b0;
        check_output("rst_mid.read_phase_ready", {31'h0, req_ready}, 32'd0);
        rst_n = 1'b0;
        tick();
        check_output("rst_mid.ready",    {31'h0, req_ready},  32'd1);
        check_output("rst_mid.mem_rw",   {31'h0, mem_rw},     32'd0);
        check_output("rst_mid.mem_addr", mem_addr,            32'h0);
        rst_n     = 1'b1;
        seen_resp = 1'b0;
        seen_rw   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (resp_valid) seen_resp = 1'b1;
            if (mem_rw)     seen_rw   = 1'b1;
            tick();
        end
        check_output("rst_mid.no_resp",  {31'h0, seen_resp}, 32'd0);
        check_output("rst_mid.no_write", {31'h0, seen_rw},    32'd0);
        check_output("rst_mid.mem",      mem[3],              32'hDEAD_BEEF);
        apply_stimulus(1'b0, 3'b010, 32'hC, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 0, "rst_mid.lw");

        // Back-to-back: valid held high across SW then LW to the same word
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h40;
        req_wdata  = 32'hCAFE_F00D;
        e.rdata = 32'h0; e.fault = 1'b0; e.lat = 2; e.wr = 1;
        sb.push_back(e);
        tick();
        check_output("b2b.t1_ready",  {31'h0, req_ready}, 32'd0);
        check_output("b2b.t1_mem_rw", {31'h0, mem_rw},    32'd1);
        tick();
        check_output("b2b.t2_resp_valid", {31'h0, resp_valid}, 32'd1);
        check_output("b2b.t2_ready",      {31'h0, req_ready},  32'd0);
        e = sb.pop_front();
        check_output("b2b.sw_rdata", resp_rdata, e.rdata);
        check_output("b2b.sw_fault", {31'h0, resp_fault}, {31'h0, e.fault});
        req_we     = 1'b0;
        req_wdata  = 32'h0;
        e.rdata = 32'hCAFE_F00D; e.fault = 1'b0; e.lat = 2; e.wr = 0;
        sb.push_back(e);
        tick();
        check_output("b2b.t3_ready",      {31'h0, req_ready},  32'd1);
        check_output("b2b.t3_resp_valid", {31'h0, resp_valid}, 32'd0);
        tick();
        req_valid = 1'b0;
        check_output("b2b.t4_ready", {31'h0, req_ready}, 32'd0);
        tick();
        check_output("b2b.t5_resp_valid", {31'h0, resp_valid}, 32'd1);
        e = sb.pop_front();
        check_output("b2b.lw_rdata", resp_rdata, e.rdata);
        check_output("b2b.lw_fault", {31'h0, resp_fault}, {31'h0, e.fault});
        tick();
        check_output("b2b.mem", mem[16], 32'hCAFE_F00D);
        check_output("b2b.idle_ready", {31'h0, req_ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Core-side initiator for the word-wide data memory. Accepts one load/store request at a time from the execute stage and sequences word reads and writes on the memory port. Handles RISC-V byte/halfword loads with sign/zero extension. Because the memory has no byte enables, sub-word stores are done as read-modify-write. Sits between the execute/writeback logic and the `memory` block, taking the place of direct MAR/MDR control.

## Interface
Parameters:
- `MEM_WORDS`, 4096 — memory depth in 32-bit words. `mem_addr` wraps modulo this value.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `rst_n`  in  1  — reset, synchronous, active-low.
- `req_valid`  in  1  — request present.
- `req_ready`  out  1  — LSU idle and able to accept a request.
- `req_we`  in  1  — 1 = store, 0 = load.
- `req_funct3`  in  3  — 000 B, 001 H, 010 W, 100 BU, 101 HU. BU/HU are loads only.
- `req_addr`  in  32  — byte address.
- `req_wdata`  in  32  — store data. Low byte/half used for B/H.
- `resp_valid`  out  1  — one-cycle completion pulse.
- `resp_rdata`  out  32  — extended load data. 0 for stores and faults.
- `resp_fault`  out  1  — request rejected (misaligned or illegal funct3). Valid with `resp_valid`.
- `mem_rw`  out  1  — write strobe to memory.
- `mem_addr`  out  32  — word index, `req_addr[31:2]` modulo `MEM_WORDS`, zero-extended.
- `mem_wdata`  out  32  — write data.
- `mem_rdata`  in  32  — combinational read data for `mem_addr`.

## Operation
- States: IDLE, READ, WRITE, RESP.
- IDLE: `req_ready`=1. On `req_valid`, the unit latches `req_we`, `req_funct3`, `req_addr[1:0]`, `req_wdata` and loads `mem_addr`.
- Next state from IDLE after a request is accepted:
  - fault → RESP
  - load → READ
  - store W → WRITE
  - store B/H → READ
- READ: the word register captures `mem_rdata`. Next state is RESP for a load, WRITE for a store.
- WRITE: `mem_rw`=1.
  - Store W: `mem_wdata`=`req_wdata`.
  - Store B/H: `mem_wdata` is the captured word with lane `addr[1:0]` (B) or `addr[1]` (H) replaced by the store data.
  - Next state is RESP.
- RESP: `resp_valid`=1 for exactly one cycle, then IDLE. `req_ready`=0 in every state other than IDLE.
- Load extraction:
  - Byte lane is `addr[1:0]`; half lane is `addr[1]`.
  - B/H sign-extend from bit 7/15. BU/HU zero-extend. W passes the word through.
- Fault conditions:
  - funct3 ∈ {011, 110, 111}.
  - Store with funct3 100 or 101.
  - Misaligned access (see Configuration).
  - On fault: no memory access, `resp_fault`=1, `resp_rdata`=0.
- `mem_rw` is asserted only in WRITE. It is never asserted in the same cycle as a fault or in IDLE.

## Timing
- Accept cycle T is the cycle in which `req_valid & req_ready`.
- Latency to the `resp_valid` cycle:
  - Load: T+2.
  - Store W: T+2, with the write at the T+1 edge.
  - Store B/H: T+3, with the read in T+1 and the write at the T+2 edge.
  - Fault: T+1.
- Throughput: the earliest next accept is the cycle after RESP. `req_valid` held high through RESP is not accepted until IDLE.
- `mem_addr` is stable from T+1 until the next accept.
- Reset values (`rst_n`=0 at an edge): state IDLE, `req_ready`=1 after the edge. `resp_valid`, `resp_fault`, `mem_rw` = 0. `resp_rdata`, `mem_addr`, `mem_wdata` = 0. Internal word and request registers = 0.
- Reset mid-operation: the transaction is dropped and no response is issued. A WRITE state interrupted at that edge performs no write, because `mem_rw` is decoded from the state register, which is now IDLE.
- Address wrap: a byte address ≥ 4·`MEM_WORDS` aliases modulo `MEM_WORDS`. No fault is raised.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - H/HU with `addr[0]`=1 faults.
  - W with `addr[1:0]`≠0 faults.
- Not defined:
  - No misalignment fault. Offending low bits are truncated: H uses `addr[1]` with `addr[0]` ignored; W ignores `addr[1:0]`.
  - Only funct3-based faults remain.

## Test plan
- Load W after reset: mem[5]=0x8765_4321, LW addr 0x14 → `resp_valid` at T+2, `resp_rdata`=0x8765_4321, `resp_fault`=0, `mem_rw` never high.
- Sign/zero extension: mem[1]=0x80FF_7F80.
  - LB 0x4 → 0xFFFF_FF80.
  - LBU 0x4 → 0x0000_0080.
  - LB 0x5 → 0x0000_007F.
  - LH 0x6 → 0xFFFF_80FF.
  - LHU 0x6 → 0x0000_80FF.
- Sub-word store RMW: mem[2]=0x1122_3344, SB 0x9 data 0xAA → write at T+2 edge, mem[2]=0x1122_AA44, `resp_valid` at T+3. SH 0xA data 0xBEEF → mem[2]=0xBEEF_AA44.
- Faults: SW 0x2 with `LSU_MISALIGN_TRAP_EN` → `resp_fault`=1 at T+1 and mem unchanged. The same access without the macro writes mem[0]. Store with funct3 100 → fault in both builds.
- Reset mid-store: SB accepted, `rst_n`=0 during READ → no `resp_valid`, mem unchanged, `req_ready`=1 after release, and the next LW completes normally.
- Back-to-back: `req_valid` held high for SW then LW to the same address → second accept the cycle after RESP, and the load returns the stored value.
